// File: rtl/gauss_pkg.sv
// rtl/gauss_pkg.sv - shared types, 1-D Gaussian coefficient ROM and legality check
package gauss_pkg;

    localparam int IDX_W = 4;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_FINISH
    } state_t;

    // round(255*exp(-d^2/(2*sigma^2))), rows sigma 1..4, columns d 0..7
    localparam logic [7:0] G_ROM [4][8] = '{
        '{8'd255, 8'd155, 8'd35,  8'd3,   8'd0,   8'd0,   8'd0,  8'd0},
        '{8'd255, 8'd225, 8'd155, 8'd83,  8'd35,  8'd11,  8'd3,  8'd1},
        '{8'd255, 8'd241, 8'd204, 8'd155, 8'd105, 8'd64,  8'd35, 8'd17},
        '{8'd255, 8'd247, 8'd225, 8'd192, 8'd155, 8'd117, 8'd83, 8'd55}
    };

    function automatic logic size_sigma_ok(input logic [3:0] size, input logic [2:0] sigma,
                                           input int max_size);
        return size[0] && (size >= 4'd3) && (int'(size) <= max_size) &&
               (sigma >= 3'd1) && (sigma <= 3'd4);
    endfunction

endpackage

// File: rtl/gauss_1d_rom.sv
// rtl/gauss_1d_rom.sv - combinational sigma/distance to 1-D Gaussian weight lookup
module gauss_1d_rom
    import gauss_pkg::*;
(
    input  logic [2:0] i_sigma,
    input  logic [3:0] i_d,
    output logic [7:0] o_g
);

    always_comb begin
        o_g = '0;
        if ((i_sigma >= 3'd1) && (i_sigma <= 3'd4) && !i_d[3])
            o_g = G_ROM[2'(i_sigma - 3'd1)][i_d[2:0]];
    end

endmodule

// File: rtl/gauss_kernel_gen.sv
// rtl/gauss_kernel_gen.sv - builds an odd size x size Gaussian kernel one entry per cycle
module gauss_kernel_gen
    import gauss_pkg::*;
#(
    parameter int MAX_SIZE = 7,
    parameter int COEF_W   = 8,
    parameter int SUM_W    = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic                                i_abort,
    input  logic [3:0]                          i_size_sel,
    input  logic [2:0]                          i_sigma,
    output logic [MAX_SIZE*MAX_SIZE*COEF_W-1:0] o_kernel,
    output logic [SUM_W-1:0]                    o_sum,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_err
);

    localparam int N_ENT = MAX_SIZE * MAX_SIZE;
    localparam int POS_W = $clog2(N_ENT * COEF_W);

    state_t                      r_state;
    state_t                      w_state_nxt;
    idx_t                        r_size;
    idx_t                        r_row;
    idx_t                        r_col;
    logic [2:0]                  r_sigma;
    logic [N_ENT*COEF_W-1:0]     r_kernel;
    logic [SUM_W-1:0]            r_sum;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_err;

    logic                        w_legal;
    logic                        w_accept;
    logic                        w_last;
    idx_t                        w_c;
    idx_t                        w_di;
    idx_t                        w_dj;
    logic [7:0]                  w_gi;
    logic [7:0]                  w_gj;
    logic [15:0]                 w_prod;
    logic [7:0]                  w_q;
    logic [COEF_W-1:0]           w_coef;
    logic [POS_W-1:0]            w_pos;

    assign w_legal  = size_sigma_ok(i_size_sel, i_sigma, MAX_SIZE);
    assign w_accept = (r_state == ST_IDLE) && i_start && !i_abort && w_legal;
    assign w_last   = (r_row == r_size - 4'd1) && (r_col == r_size - 4'd1);

    assign w_c  = (r_size - 4'd1) >> 1;
    assign w_di = (r_row >= w_c) ? (r_row - w_c) : (w_c - r_row);
    assign w_dj = (r_col >= w_c) ? (r_col - w_c) : (w_c - r_col);

    gauss_1d_rom u_rom_row (
        .i_sigma (r_sigma),
        .i_d     (w_di),
        .o_g     (w_gi)
    );

    gauss_1d_rom u_rom_col (
        .i_sigma (r_sigma),
        .i_d     (w_dj),
        .o_g     (w_gj)
    );

    // Round half up on the 8.8 product, max 65025+128 so no overflow
    assign w_prod = w_gi * w_gj;
    assign w_q    = 8'((w_prod + 16'd128) >> 8);
    assign w_coef = COEF_W'(w_q);

    // Row 0 / col 0 occupies the most significant coefficient slot
    assign w_pos = POS_W'((N_ENT - 1 - (int'(r_row) * MAX_SIZE + int'(r_col))) * COEF_W);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept) w_state_nxt = ST_LOAD;
            ST_LOAD:    w_state_nxt = i_abort ? ST_IDLE : ST_COMPUTE;
            ST_COMPUTE: begin
                if (i_abort)     w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_FINISH;
            end
            ST_FINISH:  w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_size   <= '0;
            r_sigma  <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_kernel <= '0;
            r_sum    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= ((r_state == ST_LOAD) || (r_state == ST_COMPUTE)) && !i_abort;
            r_done  <= (r_state == ST_FINISH);
            r_err   <= (r_state == ST_IDLE) && i_start && !i_abort && !w_legal;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_size  <= i_size_sel;
                        r_sigma <= i_sigma;
                    end
                end
                ST_LOAD: begin
                    r_kernel <= '0;
                    r_sum    <= '0;
                    r_row    <= '0;
                    r_col    <= '0;
                end
                ST_COMPUTE: begin
                    if (!i_abort) begin
                        r_kernel[w_pos +: COEF_W] <= w_coef;
                        r_sum <= r_sum + SUM_W'(w_coef);
                        if (r_col == r_size - 4'd1) begin
                            r_col <= '0;
                            r_row <= r_row + 4'd1;
                        end else begin
                            r_col <= r_col + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_kernel = r_kernel;
    assign o_sum    = r_sum;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_err    = r_err;

endmodule

// File: tb/tb_gauss_kernel_gen.sv
// tb/tb_gauss_kernel_gen.sv - directed self-checking bench for gauss_kernel_gen
module tb_gauss_kernel_gen;

    localparam int MS = 7;
    localparam int CW = 8;
    localparam int SW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [3:0]        size_sel = 4'd3;
    logic [2:0]        sigma = 3'd1;
    logic [MS*MS*CW-1:0] kernel;
    logic [SW-1:0]     sum;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    int rom [4][8] = '{
        '{255, 155, 35,  3,   0,   0,   0,  0},
        '{255, 225, 155, 83,  35,  11,  3,  1},
        '{255, 241, 204, 155, 105, 64,  35, 17},
        '{255, 247, 225, 192, 155, 117, 83, 55}
    };

    always #5 clk = ~clk;

    gauss_kernel_gen #(.MAX_SIZE(MS), .COEF_W(CW), .SUM_W(SW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_abort    (abort),
        .i_size_sel (size_sel),
        .i_sigma    (sigma),
        .o_kernel   (kernel),
        .o_sum      (sum),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int get_k(input int r, input int c);
        return int'(kernel[(MS*MS - 1 - (r*MS + c))*CW +: CW]);
    endfunction

    function automatic int model_k(input int sz, input int sg, input int r, input int c);
        int cc, di, dj, gi, gj;
        if (r >= sz || c >= sz) return 0;
        cc = (sz - 1) / 2;
        di = (r > cc) ? r - cc : cc - r;
        dj = (c > cc) ? c - cc : cc - c;
        gi = (di <= 7) ? rom[sg-1][di] : 0;
        gj = (dj <= 7) ? rom[sg-1][dj] : 0;
        return (gi * gj + 128) >> 8;
    endfunction

    task automatic check_model(input string tag, input int sz, input int sg);
        int s = 0;
        for (int r = 0; r < MS; r++)
            for (int c = 0; c < MS; c++) begin
                check($sformatf("%s_k%0d%0d", tag, r, c), get_k(r, c), model_k(sz, sg, r, c));
                s += model_k(sz, sg, r, c);
            end
        check({tag, "_sum"}, int'(sum), s);
    endtask

    // Returns at the negedge following the edge that sampled start (m = 0)
    task automatic launch(input int sz, input int sg);
        @(negedge clk);
        size_sel = 4'(sz);
        sigma    = 3'(sg);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int m0, output int lat, output int ndone);
        lat   = -1;
        ndone = 0;
        for (int m = m0; m < m0 + 200; m++) begin
            if (m > m0) @(negedge clk);
            if (done) begin
                ndone++;
                if (lat < 0) lat = m;
            end
            if (lat >= 0 && m >= lat + 3) break;
        end
    endtask

    int lat, nd, nbusy, ndn;
    int bad [3][2] = '{'{4, 2}, '{5, 0}, '{9, 2}};

    initial begin
        #12;
        check("rst_kernel", int'(|kernel), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;

        // size 3, sigma 1
        launch(3, 1);
        check("s3_busy_m0", int'(busy), 0);
        wait_done(0, lat, nd);
        check("s3_latency", lat, 11);
        check("s3_ndone", nd, 1);
        check("s3_centre", get_k(1, 1), 254);
        check("s3_edge", get_k(0, 1), 154);
        check("s3_corner", get_k(2, 2), 94);
        check("s3_sum", int'(sum), 1246);
        check("s3_outside", get_k(3, 3), 0);
        check_model("s3", 3, 1);

        // size 5, sigma 2
        launch(5, 2);
        wait_done(0, lat, nd);
        check("s5_latency", lat, 27);
        check("s5_ndone", nd, 1);
        check("s5_centre", get_k(2, 2), 254);
        check("s5_21", get_k(2, 1), 224);
        check("s5_20", get_k(2, 0), 154);
        check("s5_11", get_k(1, 1), 198);
        check("s5_00", get_k(0, 0), 94);
        check("s5_sum", int'(sum), 4022);
        check_model("s5", 5, 2);

        // rejected starts
        for (int i = 0; i < 3; i++) begin
            launch(bad[i][0], bad[i][1]);
            check($sformatf("err%0d_pulse", i), int'(err), 1);
            check($sformatf("err%0d_busy", i), int'(busy), 0);
            @(negedge clk);
            check($sformatf("err%0d_clear", i), int'(err), 0);
            check($sformatf("err%0d_busy1", i), int'(busy), 0);
        end
        check("err_keep_sum", int'(sum), 4022);
        check("err_keep_centre", get_k(2, 2), 254);

        // abort during a size 7 build after four entries
        launch(7, 4);
        repeat (5) @(negedge clk);
        check("ab_busy_before", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy_after", int'(busy), 0);
        check("ab_sum", int'(sum), 689);
        check("ab_k00", get_k(0, 0), 144);
        check("ab_k03", get_k(0, 3), 191);
        check("ab_k04", get_k(0, 4), 0);
        ndn = 0;
        nbusy = 0;
        repeat (60) begin
            @(negedge clk);
            ndn += int'(done);
            nbusy += int'(busy);
        end
        check("ab_no_done", ndn, 0);
        check("ab_no_busy", nbusy, 0);
        launch(7, 4);
        wait_done(0, lat, nd);
        check("s7_latency", lat, 51);
        check("s7_ndone", nd, 1);
        check_model("s7", 7, 4);

        // start pulsed while busy is ignored
        launch(3, 2);
        repeat (4) @(negedge clk);
        size_sel = 4'd5;
        sigma    = 3'd1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(5, lat, nd);
        check("ign_latency", lat, 11);
        check("ign_ndone", nd, 1);
        check("ign_sum", int'(sum), 1942);
        nbusy = 0;
        ndn = 0;
        repeat (40) begin
            @(negedge clk);
            nbusy += int'(busy);
            ndn += int'(done);
        end
        check("ign_no_rebuild", nbusy, 0);
        check("ign_no_done", ndn, 0);

        // start and abort together in IDLE
        @(negedge clk);
        size_sel = 4'd3;
        sigma    = 3'd1;
        start    = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        abort    = 1'b0;
        nbusy = 0;
        ndn = 0;
        repeat (20) begin
            @(negedge clk);
            nbusy += int'(busy);
            ndn += int'(done);
        end
        check("sa_busy", nbusy, 0);
        check("sa_done", ndn, 0);
        check("sa_sum", int'(sum), 1942);

        // asynchronous reset mid-compute
        launch(5, 2);
        repeat (6) @(negedge clk);
        check("mr_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("mr_kernel", int'(|kernel), 0);
        check("mr_sum", int'(sum), 0);
        check("mr_busy", int'(busy), 0);
        check("mr_done", int'(done), 0);
        check("mr_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        launch(3, 1);
        wait_done(0, lat, nd);
        check("mr_latency", lat, 11);
        check("mr_sum_after", int'(sum), 1246);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
